// File: rtl/pmbist_march_engine_pkg.sv
// Shared defines for the PMBIST march engine: instruction word layout,
// field extract/build helpers, address-mode and FSM encodings.
package pmbist_march_engine_pkg;

    localparam int SCAN_WIDTH   = 22;

    localparam int IR_ADMD_LSB  = 0;
    localparam int IR_ADMD_W    = 2;
    localparam int IR_W_LSB     = 2;
    localparam int IR_DATA_LSB  = 3;
    localparam int IR_DATA_W    = 8;
    localparam int IR_NO_LSB    = 11;
    localparam int IR_NO_W      = 2;
    localparam int IR_POL_LSB   = 13;
    localparam int IR_POL_W     = 4;
    localparam int IR_OP_LSB    = 17;
    localparam int IR_OP_W      = 4;
    localparam int IR_UPDWN_LSB = 21;

    typedef logic [SCAN_WIDTH-1:0] ir_t;

    typedef enum logic [1:0] {
        ADMD_ALL  = 2'd0,
        ADMD_EVEN = 2'd1,
        ADMD_ODD  = 2'd2,
        ADMD_ZERO = 2'd3
    } admd_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic admd_e ir_admd(ir_t ir);
        return admd_e'(ir[IR_ADMD_LSB +: IR_ADMD_W]);
    endfunction

    function automatic logic ir_w(ir_t ir);
        return ir[IR_W_LSB];
    endfunction

    function automatic logic [IR_DATA_W-1:0] ir_data(ir_t ir);
        return ir[IR_DATA_LSB +: IR_DATA_W];
    endfunction

    function automatic logic [IR_NO_W-1:0] ir_no(ir_t ir);
        return ir[IR_NO_LSB +: IR_NO_W];
    endfunction

    function automatic logic [IR_POL_W-1:0] ir_pol(ir_t ir);
        return ir[IR_POL_LSB +: IR_POL_W];
    endfunction

    function automatic logic [IR_OP_W-1:0] ir_op(ir_t ir);
        return ir[IR_OP_LSB +: IR_OP_W];
    endfunction

    function automatic logic ir_updwn(ir_t ir);
        return ir[IR_UPDWN_LSB];
    endfunction

    function automatic ir_t ir_build(
        logic [IR_ADMD_W-1:0] admd,
        logic                 w,
        logic [IR_DATA_W-1:0] data,
        logic [IR_NO_W-1:0]   no,
        logic [IR_POL_W-1:0]  pol,
        logic [IR_OP_W-1:0]   op,
        logic                 updwn
    );
        ir_t r;
        r = '0;
        r[IR_ADMD_LSB +: IR_ADMD_W] = admd;
        r[IR_W_LSB]                 = w;
        r[IR_DATA_LSB +: IR_DATA_W] = data;
        r[IR_NO_LSB +: IR_NO_W]     = no;
        r[IR_POL_LSB +: IR_POL_W]   = pol;
        r[IR_OP_LSB +: IR_OP_W]     = op;
        r[IR_UPDWN_LSB]             = updwn;
        return r;
    endfunction

endpackage

// File: rtl/pmbist_march_engine_if.sv
// Single-port memory bus between the march engine (master)
// and the memory under test (slave).
interface pmbist_march_engine_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_we,
        output mem_re,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        input  mem_re,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/pmbist_addr_gen.sv
// March address generator: start/end/step per address mode and
// direction; termination is a compare against the end address.
module pmbist_addr_gen
    import pmbist_march_engine_pkg::*;
#(
    parameter int AW = 4
) (
    input  admd_e         admd,
    input  logic          updwn,
    input  logic [AW-1:0] addr,
    output logic [AW-1:0] start,
    output logic          last,
    output logic [AW-1:0] next
);
    logic [AW-1:0] lo;
    logic [AW-1:0] hi;
    logic [AW-1:0] step;
    logic [AW-1:0] stop;

    always_comb begin
        lo   = '0;
        hi   = '1;
        step = AW'(1);
        unique case (admd)
            ADMD_ALL: ;
            ADMD_EVEN: begin
                hi   = {{(AW-1){1'b1}}, 1'b0};
                step = AW'(2);
            end
            ADMD_ODD: begin
                lo   = AW'(1);
                step = AW'(2);
            end
            ADMD_ZERO: hi = '0;
        endcase
        start = updwn ? hi : lo;
        stop  = updwn ? lo : hi;
        last  = (addr == stop);
        next  = updwn ? addr - step : addr + step;
    end
endmodule

// File: rtl/pmbist_march_engine.sv
// March-element engine: latches one IR on ts rise, walks the address
// space issuing the op group per address, reports sticky pass/fail.
module pmbist_march_engine
    import pmbist_march_engine_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SCAN_WIDTH-1:0] scan,
    input  logic                  ts,
    pmbist_march_engine_if.master mif,
    output logic                  busy,
    output logic                  done,
    output logic                  passfail,
    output logic [AW-1:0]         fail_addr
);
    state_e        state_q, state_d;
    ir_t           ir_q, ir_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    op_q, op_d;
    logic          ts_q;
    logic          fail_q, fail_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic          cmp_vld_q, cmp_vld_d;
    logic [DW-1:0] cmp_exp_q, cmp_exp_d;
    logic [AW-1:0] cmp_addr_q, cmp_addr_d;

    ir_t           ir_sel;
    admd_e         sel_admd;
    logic          sel_updwn;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] next_addr;
    logic          last_addr;
    logic [3:0]    ops;
    logic [3:0]    pols;
    logic          op_we;
    logic [DW-1:0] wdata;
    logic          we;
    logic          re;

    // In IDLE the start address must come from the word being loaded.
    always_comb begin
        ir_sel    = (state_q == ST_IDLE) ? scan : ir_q;
        sel_admd  = ir_admd(ir_sel);
        sel_updwn = ir_updwn(ir_sel);
        ops       = ir_op(ir_q);
        pols      = ir_pol(ir_q);
        op_we     = ops[op_q];
        wdata     = DW'(ir_data(ir_q)) ^ {DW{pols[op_q]}};
    end

    pmbist_addr_gen #(.AW(AW)) u_addr_gen (
        .admd  (sel_admd),
        .updwn (sel_updwn),
        .addr  (addr_q),
        .start (start_addr),
        .last  (last_addr),
        .next  (next_addr)
    );

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        addr_d      = addr_q;
        op_d        = op_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        cmp_vld_d   = 1'b0;
        cmp_exp_d   = cmp_exp_q;
        cmp_addr_d  = cmp_addr_q;
        we          = 1'b0;
        re          = 1'b0;

        if (cmp_vld_q && (mif.mem_rdata != cmp_exp_q) && !fail_q) begin
            fail_d      = 1'b1;
            fail_addr_d = cmp_addr_q;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (ts && !ts_q) begin
                    ir_d        = scan;
                    addr_d      = start_addr;
                    op_d        = 2'd0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                we = op_we;
                re = !op_we;
                if (!op_we) begin
                    cmp_vld_d  = 1'b1;
                    cmp_exp_d  = wdata;
                    cmp_addr_d = addr_q;
                end
                if (op_q == ir_no(ir_q)) begin
                    op_d = 2'd0;
                    if (last_addr) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = next_addr;
                        if (ir_w(ir_q)) state_d = ST_PAUSE;
                    end
                end else begin
                    op_d = op_q + 2'd1;
                end
            end
            ST_PAUSE: state_d = ST_RUN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE: begin
                if (!ts) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ir_q        <= '0;
            addr_q      <= '0;
            op_q        <= '0;
            ts_q        <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            ts_q        <= ts;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_exp_q   <= cmp_exp_d;
            cmp_addr_q  <= cmp_addr_d;
        end
    end

    assign mif.mem_addr  = addr_q;
    assign mif.mem_we    = we;
    assign mif.mem_re    = re;
    assign mif.mem_wdata = (state_q == ST_RUN) ? wdata : '0;

    assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE)
                    || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign passfail  = done && !fail_q;
    assign fail_addr = fail_addr_q;
endmodule

// File: tb/tb_pmbist_march_engine.sv
// Directed bench for pmbist_march_engine: memory model with fault
// injection and an op scoreboard filled from each command.
module tb_pmbist_march_engine;
    import pmbist_march_engine_pkg::*;

    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
    } op_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [SCAN_WIDTH-1:0] scan;
    logic       ts;
    logic       busy;
    logic       done;
    logic       passfail;
    logic [3:0] fail_addr;

    int vectors = 0;
    int miscompares = 0;

    op_t        sb[$];
    logic [7:0] mem [16];
    logic [15:0] fault = '0;

    pmbist_march_engine_if #(.AW(4), .DW(8)) mif ();

    pmbist_march_engine #(.AW(4), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .scan      (scan),
        .ts        (ts),
        .mif       (mif),
        .busy      (busy),
        .done      (done),
        .passfail  (passfail),
        .fail_addr (fail_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Synchronous memory; faulty addresses read back with bit 0 stuck at 0.
    always @(posedge clk) begin
        logic [7:0] d;
        if (mif.mem_we) mem[mif.mem_addr] <= mif.mem_wdata;
        if (mif.mem_re) begin
            d = mem[mif.mem_addr];
            if (fault[mif.mem_addr]) d[0] = 1'b0;
            mif.mem_rdata <= d;
        end
    end

    always @(negedge clk) begin
        op_t e;
        if (rst && (mif.mem_we || mif.mem_re)) begin
            check("we_re_excl", {31'd0, mif.mem_we & mif.mem_re}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_op", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("op", {mif.mem_we, mif.mem_re, mif.mem_addr,
                             mif.mem_wdata},
                      {e.we, ~e.we, e.addr, e.data});
            end
        end
    end

    task automatic push_cmd(input ir_t ir);
        int   addrs[$];
        logic [1:0] md;
        logic [3:0] op;
        logic [3:0] pol;
        logic [7:0] dat;
        int   no;
        md  = ir_admd(ir);
        op  = ir_op(ir);
        pol = ir_pol(ir);
        dat = ir_data(ir);
        no  = int'(ir_no(ir));
        for (int a = 0; a < 16; a++) begin
            if ((md == 2'd0) || (md == 2'd1 && a % 2 == 0)
                || (md == 2'd2 && a % 2 == 1) || (md == 2'd3 && a == 0))
                addrs.push_back(a);
        end
        if (ir_updwn(ir)) addrs.reverse();
        foreach (addrs[i]) begin
            for (int k = 0; k <= no; k++) begin
                sb.push_back({op[k], 4'(addrs[i]), dat ^ {8{pol[k]}}});
            end
        end
    endtask

    task automatic run_start(input ir_t ir);
        @(negedge clk);
        scan = ir;
        ts   = 1'b1;
        push_cmd(ir);
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        check(tag, n, exp_cyc);
        check({tag, "_sb_drained"}, sb.size(), 0);
    endtask

    ir_t c_m3, c_m0, c_m1, c_alt;

    initial begin
        c_m3  = ir_build(2'd3, 1'b0, 8'hFA, 2'd3, 4'b1100, 4'b0101, 1'b0);
        c_m0  = ir_build(2'd0, 1'b0, 8'h55, 2'd1, 4'b0000, 4'b0001, 1'b0);
        c_m1  = ir_build(2'd1, 1'b1, 8'hA5, 2'd0, 4'b0000, 4'b0001, 1'b1);
        c_alt = ir_build(2'd3, 1'b0, 8'hCC, 2'd0, 4'b1111, 4'b1111, 1'b0);

        rst  = 1'b0;
        ts   = 1'b0;
        scan = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_passfail", passfail, 0);
        check("rst_we", mif.mem_we, 0);
        check("rst_re", mif.mem_re, 0);
        check("rst_fail_addr", fail_addr, 0);
        check("rst_addr", mif.mem_addr, 0);
        rst = 1'b1;
        @(negedge clk);

        // Mode 3 single address, four ops.
        run_start(c_m3);
        wait_done("m3_latency", 6);
        check("m3_pass", passfail, 1);
        check("m3_busy", busy, 0);
        ts = 1'b0;
        @(negedge clk);
        check("m3_done_clr", done, 0);
        check("m3_pf_clr", passfail, 0);

        // Mode 0 ascending, good memory.
        run_start(c_m0);
        wait_done("m0_latency", 34);
        check("m0_pass", passfail, 1);
        ts = 1'b0;
        @(negedge clk);

        // Same march with faults at 9 and 12: first one is reported.
        fault = 16'h1200;
        run_start(c_m0);
        wait_done("flt_latency", 34);
        check("flt_pass", passfail, 0);
        check("flt_addr", fail_addr, 9);
        fault = '0;
        ts = 1'b0;
        @(negedge clk);

        // Even addresses descending with an idle cycle after each.
        run_start(c_m1);
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            check("m1_strobe_pat", {31'd0, mif.mem_we | mif.mem_re},
                  {31'd0, (n % 2 == 1) && (n <= 15)});
        end
        check("m1_done", done, 1);
        check("m1_pass", passfail, 1);
        check("m1_sb_drained", sb.size(), 0);
        ts = 1'b0;
        @(negedge clk);

        // ts pulse and scan change mid-run are ignored.
        run_start(c_m0);
        repeat (5) @(negedge clk);
        ts   = 1'b0;
        scan = c_alt;
        @(negedge clk);
        ts = 1'b1;
        @(negedge clk);
        check("mid_busy", busy, 1);
        wait_done("mid_latency", 34 - 7);
        check("mid_pass", passfail, 1);
        repeat (10) @(negedge clk);
        check("hold_done", done, 1);
        check("hold_busy", busy, 0);
        check("hold_sb", sb.size(), 0);
        ts = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of a run.
        run_start(c_m0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("ar_we", mif.mem_we, 0);
        check("ar_re", mif.mem_re, 0);
        check("ar_busy", busy, 0);
        check("ar_done", done, 0);
        check("ar_passfail", passfail, 0);
        sb.delete();
        ts = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_start(c_m3);
        wait_done("ar_rerun_latency", 6);
        check("ar_rerun_pass", passfail, 1);
        ts = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pmbist_march_engine.md
Name: pmbist_march_engine

Overview:
- Consumer end of the BIST scan/ts instruction interface.
- Latches one march-element instruction word from `scan` when `ts` rises.
- Walks the address space and issues the encoded write/read sequence to a single-port memory, comparing read data against expected values.
- Reports a sticky pass/fail result plus the first failing address; sits between the scan controller and the memory under test inside the memory IP block.

Parameters:
- AW, 4, memory address width in bits.
- DW, 8, memory data width; must equal the IR DATA field width.
- SCAN_WIDTH, 22, instruction word width; taken from the shared defines.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- scan  in  SCAN_WIDTH  instruction word; sampled only on the load cycle.
- ts  in  1  test start, level signal; a 0→1 transition starts a run.
- mem_addr  out  AW  memory address.
- mem_we  out  1  write strobe, one cycle per write.
- mem_re  out  1  read strobe, one cycle per read.
- mem_wdata  out  DW  write data.
- mem_rdata  in  DW  read data, valid the cycle after mem_re.
- busy  out  1  run in progress.
- done  out  1  run complete; held until ts falls.
- passfail  out  1  1 = pass; meaningful only while done=1.
- fail_addr  out  AW  address of the first miscompare.

Behaviour:
- IR layout, LSB first:
  - ADMD[1:0]
  - W[2]
  - DATA[10:3]
  - NO[12:11]
  - POL0..POL3[16:13]
  - OP0..OP3[20:17]
  - UPDWN[21]
- Field meanings:
  - OPk: 1 = write, 0 = read.
  - POLk: 1 = invert DATA for op k.
  - NO: op count minus 1.
  - UPDWN: 0 = ascending, 1 = descending.
- ADMD address modes:
  - 0 = all addresses.
  - 1 = even addresses only.
  - 2 = odd addresses only.
  - 3 = address 0 only.
- W=1 inserts one idle cycle after each address's op group.
- Reset values: every output 0; internal fail flag 0; FSM in IDLE.
- FSM states: IDLE, RUN, PAUSE, DRAIN, DONE.
- IDLE:
  - ts rising edge (ts=1 with registered ts=0) → load IR from scan, set the start address, op index = 0, busy=1, go to RUN.
- RUN:
  - One op per cycle, op 0 first.
  - Drives mem_addr, mem_we or mem_re, and mem_wdata = DATA ^ {DW{POLk}}.
  - Start address:
    - Ascending: lowest address in the mode.
    - Descending: highest address in the mode; mode 1 → 2^AW−2, mode 2 → 2^AW−1.
  - Address step is 1 for mode 0 and 2 for modes 1/2.
  - After op NO: advance address (or go to PAUSE if W=1).
  - After the last address's op NO: go to DRAIN.
- PAUSE: one cycle with no strobes, then RUN at the next address.
- Compare pipeline:
  - Each read registers its expected value and address.
  - On the next cycle, mem_rdata is compared.
  - On a mismatch with fail=0: fail ← 1 and fail_addr ← registered address.
  - Later mismatches do not overwrite fail_addr.
- DRAIN: one cycle so the final read is compared; no strobes; then DONE.
- DONE:
  - busy=0, done=1, passfail=~fail.
  - Stays in DONE while ts=1; ts=0 → IDLE, with done and passfail cleared.
- Latency, mode 3, NO=3, W=0:
  - ts-rise sample edge = cycle 0.
  - Ops on cycles 1–4, DRAIN on cycle 5, done=1 from cycle 6.
- Edge cases:
  - ts held high after DONE: no restart; a new run requires ts low then high.
  - ts or scan activity while busy: ignored; the IR stays frozen.
  - mem_we and mem_re are never high together.
  - Address counter never wraps; termination is detected by comparing against the end address before increment or decrement.
  - Async reset mid-run: strobes drop immediately, all state returns to reset values, no partial result is reported.

Decomposition:
- Shared defines file holds:
  - SCAN_WIDTH;
  - IR field LSB/width constants and extract macros (IR_UPDWN…IR_ADMD), reused by benches to build commands;
  - ADMD mode encodings;
  - FSM state encodings.
- One natural sub-module: pmbist_addr_gen. It covers start/end/step per ADMD and UPDWN and exposes `last` and `next` outputs.

Test Plan:
- Mode 3, NO=3, ops W,R,W,R, POL=0,0,1,1, DATA=8'hFA, good memory → writes FA then 05 at addr 0; done at cycle 6; passfail=1.
- Mode 0, ascending, AW=4, ops W,R, DATA=8'h55 → 32 op cycles over addr 0..15, then DRAIN; done at cycle 34; passfail=1.
- Same as the previous case with bit 0 of addr 9 stuck-at-0 → passfail=0, fail_addr=9; a later fault injected at addr 12 still leaves fail_addr=9.
- Mode 1, descending, W=1, NO=0 write → addresses 14,12,…,0, each followed by one idle cycle; no odd address is touched.
- ts pulsed and scan changed mid-run → no restart and the IR is unchanged; ts held high after done → no second run.
- rst asserted on cycle 3 of a run → mem_we, mem_re, busy, done and passfail are 0 asynchronously; after release, a fresh ts rise runs to completion.
